// File: rtl/csr_ex_ctrl_if.sv
// Writeback-side, CSR-side and fetch-redirect signals of the exception controller.
// The pipeline/CSR/front-end side is master; csr_ex_ctrl is slave.
interface csr_ex_ctrl_if;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_ex_req;
    logic [5:0]  wb_ecode_in;
    logic [8:0]  wb_esubcode_in;
    logic [31:0] wb_vaddr_in;
    logic        wb_ertn;
    logic [12:0] csr_estat_is;
    logic [12:0] csr_ecfg_lie;
    logic        csr_crmd_ie;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_csr_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic        wb_commit_en;
    logic        flush_pipe;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (
        output wb_valid, wb_pc, wb_ex_req, wb_ecode_in, wb_esubcode_in, wb_vaddr_in, wb_ertn,
        output csr_estat_is, csr_ecfg_lie, csr_crmd_ie, ex_entry, ertn_entry, redirect_ready,
        input  wb_ex, wb_ecode, wb_esubcode, wb_csr_pc, wb_vaddr, ertn_flush,
        input  wb_commit_en, flush_pipe, redirect_valid, redirect_pc
    );

    modport slave (
        input  wb_valid, wb_pc, wb_ex_req, wb_ecode_in, wb_esubcode_in, wb_vaddr_in, wb_ertn,
        input  csr_estat_is, csr_ecfg_lie, csr_crmd_ie, ex_entry, ertn_entry, redirect_ready,
        output wb_ex, wb_ecode, wb_esubcode, wb_csr_pc, wb_vaddr, ertn_flush,
        output wb_commit_en, flush_pipe, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/csr_ex_ctrl.sv
// Exception/interrupt/ERTN sequencer: commit pulses in the WB event cycle, then flush + fetch redirect.
// Event outputs are combinational in cycle T; redirect from T+1 held until redirect_ready; then DRAIN_CYCLES of flush.
module csr_ex_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    csr_ex_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REDIR, DRAIN} state_t;

    localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] target, target_nxt;
    logic        int_pending;

    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] csr_pc;
    logic [31:0] vaddr;
    logic        ertn_flush;
    logic        commit_en;
    logic        flush;
    logic        redir_vld;
    logic [31:0] redir_pc;

    assign int_pending = bus.csr_crmd_ie & (|(bus.csr_estat_is & bus.csr_ecfg_lie));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            target <= 32'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            target <= target_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        target_nxt = target;
        ex         = 1'b0;
        ecode      = 6'd0;
        esubcode   = 9'd0;
        csr_pc     = 32'd0;
        vaddr      = 32'd0;
        ertn_flush = 1'b0;
        commit_en  = 1'b0;
        flush      = 1'b0;
        redir_vld  = 1'b0;
        redir_pc   = 32'd0;

        case (state)
            IDLE: begin
                if (bus.wb_valid) begin
                    // Interrupt outranks both a pipeline exception and ERTN on the same instruction.
                    if (int_pending || bus.wb_ex_req) begin
                        ex         = 1'b1;
                        ecode      = int_pending ? 6'h00 : bus.wb_ecode_in;
                        esubcode   = int_pending ? 9'd0  : bus.wb_esubcode_in;
                        csr_pc     = bus.wb_pc;
                        vaddr      = bus.wb_vaddr_in;
                        flush      = 1'b1;
                        target_nxt = bus.ex_entry;
                        state_nxt  = REDIR;
                    end else if (bus.wb_ertn) begin
                        ertn_flush = 1'b1;
                        flush      = 1'b1;
                        target_nxt = bus.ertn_entry;
                        state_nxt  = REDIR;
                    end else begin
                        commit_en  = 1'b1;
                    end
                end
            end
            REDIR: begin
                redir_vld = 1'b1;
                redir_pc  = target;
                flush     = 1'b1;
                if (bus.redirect_ready) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DRAIN;
                        cnt_nxt   = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                flush = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A reset cycle presents all-zero outputs regardless of the state being abandoned.
        if (reset) begin
            ex         = 1'b0;
            ecode      = 6'd0;
            esubcode   = 9'd0;
            csr_pc     = 32'd0;
            vaddr      = 32'd0;
            ertn_flush = 1'b0;
            commit_en  = 1'b0;
            flush      = 1'b0;
            redir_vld  = 1'b0;
            redir_pc   = 32'd0;
        end
    end

    assign bus.wb_ex          = ex;
    assign bus.wb_ecode       = ecode;
    assign bus.wb_esubcode    = esubcode;
    assign bus.wb_csr_pc      = csr_pc;
    assign bus.wb_vaddr       = vaddr;
    assign bus.ertn_flush     = ertn_flush;
    assign bus.wb_commit_en   = commit_en;
    assign bus.flush_pipe     = flush;
    assign bus.redirect_valid = redir_vld;
    assign bus.redirect_pc    = redir_pc;
endmodule

// File: tb/tb_csr_ex_ctrl.sv
// Per-cycle vector table run against two instances (DRAIN_CYCLES=2 and 0), expectations queued and popped at negedge.
// Outputs sampled at negedge, one cycle of inputs per vector.
// redirect_ready is driven per vector to exercise backpressure; a watchdog bounds total run time.
module tb_csr_ex_ctrl;
    localparam logic [31:0] EXE = 32'h1C00_8000;
    localparam logic [31:0] ERE = 32'h1C00_0104;
    localparam int          MAX_CYCLES = 2000;

    typedef struct packed {
        logic        ex;
        logic [5:0]  ec;
        logic [8:0]  es;
        logic [31:0] pc;
        logic [31:0] va;
        logic        er;
        logic        ce;
        logic        fl;
        logic        rv;
        logic [31:0] rpc;
    } out_t;

    typedef struct packed {
        logic        which;
        logic        rst;
        logic        wv;
        logic [31:0] pc;
        logic        exr;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] vaddr;
        logic        ertn;
        logic [12:0] is;
        logic [12:0] lie;
        logic        ie;
        logic        ready;
        out_t        exp;
    } vec_t;

    logic clk;
    logic rst0, rst1;
    vec_t cur;
    vec_t vecs[$];
    vec_t exp_q[$];
    out_t o0, o1;
    int   n_vec = 0;
    int   n_err = 0;
    logic done = 1'b0;

    csr_ex_ctrl_if b0 ();
    csr_ex_ctrl_if b1 ();

    csr_ex_ctrl #(.DRAIN_CYCLES(2)) dut0 (.clk(clk), .reset(rst0), .bus(b0));
    csr_ex_ctrl #(.DRAIN_CYCLES(0)) dut1 (.clk(clk), .reset(rst1), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The instance not under test is held in reset.
    assign rst0 = cur.rst | cur.which;
    assign rst1 = cur.rst | ~cur.which;

    assign b0.wb_valid = cur.wv;        assign b1.wb_valid = cur.wv;
    assign b0.wb_pc = cur.pc;           assign b1.wb_pc = cur.pc;
    assign b0.wb_ex_req = cur.exr;      assign b1.wb_ex_req = cur.exr;
    assign b0.wb_ecode_in = cur.ecode;  assign b1.wb_ecode_in = cur.ecode;
    assign b0.wb_esubcode_in = cur.esub; assign b1.wb_esubcode_in = cur.esub;
    assign b0.wb_vaddr_in = cur.vaddr;  assign b1.wb_vaddr_in = cur.vaddr;
    assign b0.wb_ertn = cur.ertn;       assign b1.wb_ertn = cur.ertn;
    assign b0.csr_estat_is = cur.is;    assign b1.csr_estat_is = cur.is;
    assign b0.csr_ecfg_lie = cur.lie;   assign b1.csr_ecfg_lie = cur.lie;
    assign b0.csr_crmd_ie = cur.ie;     assign b1.csr_crmd_ie = cur.ie;
    assign b0.ex_entry = EXE;           assign b1.ex_entry = EXE;
    assign b0.ertn_entry = ERE;         assign b1.ertn_entry = ERE;
    assign b0.redirect_ready = cur.ready; assign b1.redirect_ready = cur.ready;

    assign o0 = {b0.wb_ex, b0.wb_ecode, b0.wb_esubcode, b0.wb_csr_pc, b0.wb_vaddr, b0.ertn_flush,
                 b0.wb_commit_en, b0.flush_pipe, b0.redirect_valid, b0.redirect_pc};
    assign o1 = {b1.wb_ex, b1.wb_ecode, b1.wb_esubcode, b1.wb_csr_pc, b1.wb_vaddr, b1.ertn_flush,
                 b1.wb_commit_en, b1.flush_pipe, b1.redirect_valid, b1.redirect_pc};

    function automatic vec_t mk(input logic w);
        vec_t v;
        v = '0;
        v.which = w;
        v.ready = 1'b1;
        return v;
    endfunction

    task automatic add_rst(input logic w, input logic valid);
        vec_t v;
        v = mk(w);
        v.rst = 1'b1; v.wv = valid; v.exr = valid; v.pc = 32'h1C00_0040;
        vecs.push_back(v);
    endtask

    task automatic add_nop(input logic w, input logic valid);
        vec_t v;
        v = mk(w);
        v.wv = valid; v.pc = 32'h1C00_00F0;
        v.exp.ce = valid;
        vecs.push_back(v);
    endtask

    // One WB event cycle; intr raises a pending, enabled interrupt on line 2.
    task automatic add_ev(input logic w, input logic [31:0] pc, input logic exr, input logic [5:0] ec,
                          input logic [8:0] es, input logic ertn, input logic intr, input logic [31:0] va);
        vec_t v;
        v = mk(w);
        v.wv = 1'b1; v.pc = pc; v.exr = exr; v.ecode = ec; v.esub = es; v.ertn = ertn; v.vaddr = va;
        if (intr) begin
            v.ie = 1'b1; v.is = 13'h004; v.lie = 13'h004;
        end
        v.exp.fl = 1'b1;
        if (intr || exr) begin
            v.exp.ex = 1'b1;
            v.exp.ec = intr ? 6'h00 : ec;
            v.exp.es = intr ? 9'd0 : es;
            v.exp.pc = pc;
            v.exp.va = va;
        end else begin
            v.exp.er = 1'b1;
        end
        vecs.push_back(v);
    endtask

    // Wrong-path WB activity (exception, ERTN and a live interrupt) must all be ignored outside IDLE.
    task automatic add_busy(input logic w, input logic rdy, input logic redir, input logic [31:0] tgt);
        vec_t v;
        v = mk(w);
        v.wv = 1'b1; v.exr = 1'b1; v.ecode = 6'h3F; v.ertn = 1'b1; v.pc = 32'h1C00_0F00;
        v.ie = 1'b1; v.is = 13'h004; v.lie = 13'h004;
        v.ready = rdy;
        v.exp.fl = 1'b1;
        v.exp.rv = redir;
        v.exp.rpc = redir ? tgt : 32'd0;
        vecs.push_back(v);
    endtask

    initial begin
        repeat (MAX_CYCLES) @(posedge clk);
        if (!done) begin
            n_err++;
            $display("FAIL timeout: vector run did not finish within %0d cycles", MAX_CYCLES);
            $finish;
        end
    end

    initial begin
        vec_t v;
        vec_t e;
        out_t act;
        cur = '0;
        cur.rst = 1'b1;

        @(posedge clk);
        @(negedge clk);
        if (o0 !== '0 || o1 !== '0) begin
            n_err++;
            $display("FAIL reset state: dut0 outputs %h dut1 outputs %h, required all zero", o0, o1);
        end

        // DRAIN_CYCLES=2
        add_rst(1'b0, 1'b1);
        add_nop(1'b0, 1'b1);
        add_nop(1'b0, 1'b0);
        add_ev(1'b0, 32'h1C00_0100, 1'b1, 6'h0B, 9'h000, 1'b0, 1'b0, 32'h0000_1234);
        add_busy(1'b0, 1'b1, 1'b1, EXE);
        add_busy(1'b0, 1'b1, 1'b0, EXE);
        add_busy(1'b0, 1'b1, 1'b0, EXE);
        add_nop(1'b0, 1'b1);
        add_ev(1'b0, 32'h1C00_0500, 1'b0, 6'h00, 9'h000, 1'b1, 1'b0, 32'h0);
        add_busy(1'b0, 1'b1, 1'b1, ERE);
        add_busy(1'b0, 1'b1, 1'b0, ERE);
        add_busy(1'b0, 1'b1, 1'b0, ERE);
        add_nop(1'b0, 1'b1);
        add_ev(1'b0, 32'h1C00_0200, 1'b1, 6'h0B, 9'h005, 1'b0, 1'b1, 32'h0000_0BAD);
        add_busy(1'b0, 1'b1, 1'b1, EXE);
        add_busy(1'b0, 1'b1, 1'b0, EXE);
        add_busy(1'b0, 1'b1, 1'b0, EXE);
        add_nop(1'b0, 1'b1);
        add_ev(1'b0, 32'h1C00_0204, 1'b0, 6'h00, 9'h000, 1'b1, 1'b1, 32'h0);
        add_busy(1'b0, 1'b1, 1'b1, EXE);
        add_busy(1'b0, 1'b1, 1'b0, EXE);
        add_busy(1'b0, 1'b1, 1'b0, EXE);
        add_nop(1'b0, 1'b1);
        v = mk(1'b0); v.ie = 1'b1; v.is = 13'h004; v.lie = 13'h004; vecs.push_back(v);
        v = mk(1'b0); v.wv = 1'b1; v.ie = 1'b1; v.is = 13'h004; v.lie = 13'h008; v.exp.ce = 1'b1; vecs.push_back(v);
        v = mk(1'b0); v.wv = 1'b1; v.ie = 1'b0; v.is = 13'h004; v.lie = 13'h004; v.exp.ce = 1'b1; vecs.push_back(v);
        add_ev(1'b0, 32'h1C00_0300, 1'b1, 6'h08, 9'h001, 1'b0, 1'b0, 32'hDEAD_BEE0);
        for (int i = 0; i < 5; i++) add_busy(1'b0, 1'b0, 1'b1, EXE);
        add_busy(1'b0, 1'b1, 1'b1, EXE);
        add_busy(1'b0, 1'b1, 1'b0, EXE);
        add_busy(1'b0, 1'b1, 1'b0, EXE);
        add_nop(1'b0, 1'b1);
        add_ev(1'b0, 32'h1C00_0400, 1'b1, 6'h09, 9'h000, 1'b0, 1'b0, 32'h1C00_0401);
        add_busy(1'b0, 1'b0, 1'b1, EXE);
        add_rst(1'b0, 1'b1);
        add_nop(1'b0, 1'b0);
        add_ev(1'b0, 32'h1C00_0410, 1'b1, 6'h01, 9'h000, 1'b0, 1'b0, 32'h0);
        add_busy(1'b0, 1'b1, 1'b1, EXE);
        add_busy(1'b0, 1'b1, 1'b0, EXE);
        add_busy(1'b0, 1'b1, 1'b0, EXE);
        add_nop(1'b0, 1'b1);

        // DRAIN_CYCLES=0
        add_rst(1'b1, 1'b0);
        add_ev(1'b1, 32'h1C00_0100, 1'b1, 6'h0B, 9'h000, 1'b0, 1'b0, 32'h0);
        add_busy(1'b1, 1'b1, 1'b1, EXE);
        add_nop(1'b1, 1'b1);
        add_ev(1'b1, 32'h1C00_0600, 1'b0, 6'h00, 9'h000, 1'b1, 1'b0, 32'h0);
        add_busy(1'b1, 1'b0, 1'b1, ERE);
        add_busy(1'b1, 1'b1, 1'b1, ERE);
        add_nop(1'b1, 1'b1);
        add_nop(1'b1, 1'b1);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            cur = vecs[i];
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            act = e.which ? o1 : o0;
            n_vec++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL vec%0d dut%0d got ex=%b ec=%h es=%h pc=%h va=%h er=%b ce=%b fl=%b rv=%b rpc=%h required ex=%b ec=%h es=%h pc=%h va=%h er=%b ce=%b fl=%b rv=%b rpc=%h",
                         i, e.which, act.ex, act.ec, act.es, act.pc, act.va, act.er, act.ce, act.fl, act.rv, act.rpc,
                         e.exp.ex, e.exp.ec, e.exp.es, e.exp.pc, e.exp.va, e.exp.er, e.exp.ce, e.exp.fl, e.exp.rv, e.exp.rpc);
            end
        end

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
